distancia_calc: RTL and testbench

//  Downstream stage of the ultrasonic echo counter. Consumes the echo width count and the

---
 rtl/distancia_calc.sv | 148 ++++++++++++++
 tb/tb_distancia_calc.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/distancia_calc.sv
// Ultrasonic echo ticks -> centimetres: restoring shift-subtract divider with registered result,
// valid strobe, counter clear request and near-obstacle alarm. Optional averaging: DIST_AVG_EN.
module distancia_calc #(
  parameter int COUNT_W      = 8,
  parameter int TICKS_PER_CM = 6,
  parameter int NEAR_CM      = 20
) (
  input  logic               CLKOUT,
  input  logic               reset,
  input  logic [COUNT_W-1:0] count,
  input  logic               calculate,
  output logic [COUNT_W-1:0] distance,
  output logic               valid,
  output logic               busy,
  output logic               clr_meas,
  output logic               out_of_range,
  output logic               near_alarm
);

  if (TICKS_PER_CM < 1) begin : g_bad_divisor
    $error("distancia_calc: TICKS_PER_CM must be >= 1");
  end

  localparam int IDX_W = (COUNT_W > 1) ? $clog2(COUNT_W) : 1;
  localparam logic [COUNT_W:0] DIVISOR = (COUNT_W+1)'(TICKS_PER_CM);

`ifdef DIST_AVG_EN
  typedef enum logic [2:0] {IDLE, DIV, AVG, DONE, WAIT_CLR} state_t;
`else
  typedef enum logic [2:0] {IDLE, DIV, DONE, WAIT_CLR} state_t;
`endif

  state_t state, state_nxt;

  logic [COUNT_W-1:0] dividend;
  logic [COUNT_W:0]   rem;
  logic [COUNT_W-1:0] quot;
  logic [IDX_W-1:0]   idx;
  logic [COUNT_W-1:0] result;

  logic [COUNT_W:0]   rem_shift;
  logic               rem_ge;

  assign rem_shift = {rem[COUNT_W-1:0], dividend[idx]};
  assign rem_ge    = (rem_shift >= DIVISOR);
  assign busy      = (state != IDLE);

`ifdef DIST_AVG_EN
  logic [COUNT_W-1:0] hist [4];
  logic               filled;
  logic [COUNT_W-1:0] avg_q;
  logic [COUNT_W+1:0] avg_sum;

  // New quotient enters slot 0; the oldest entry (slot 3) drops out of the sum.
  always_comb begin
    avg_sum = '0;
    if (filled)
      avg_sum = (COUNT_W+2)'(quot) + (COUNT_W+2)'(hist[0])
              + (COUNT_W+2)'(hist[1]) + (COUNT_W+2)'(hist[2]);
    else
      avg_sum = {quot, 2'b00};
  end

  assign result = avg_q;
`else
  assign result = quot;
`endif

  always_ff @(posedge CLKOUT) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (calculate) state_nxt = DIV;
`ifdef DIST_AVG_EN
      DIV:      if (idx == '0) state_nxt = AVG;
      AVG:      state_nxt = DONE;
`else
      DIV:      if (idx == '0) state_nxt = DONE;
`endif
      DONE:     state_nxt = WAIT_CLR;
      WAIT_CLR: if (!calculate) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLKOUT) begin
    if (reset) begin
      dividend     <= '0;
      rem          <= '0;
      quot         <= '0;
      idx          <= '0;
      distance     <= '0;
      valid        <= 1'b0;
      clr_meas     <= 1'b0;
      out_of_range <= 1'b0;
      near_alarm   <= 1'b0;
    end else begin
      valid    <= 1'b0;
      clr_meas <= 1'b0;
      case (state)
        IDLE: if (calculate) begin
          dividend <= count;
          rem      <= '0;
          quot     <= '0;
          idx      <= IDX_W'(COUNT_W-1);
        end
        DIV: begin
          rem       <= rem_ge ? (rem_shift - DIVISOR) : rem_shift;
          quot[idx] <= rem_ge;
          idx       <= idx - IDX_W'(1);
        end
        DONE: begin
          distance     <= result;
          out_of_range <= (dividend == '1);
          near_alarm   <= (int'(result) < NEAR_CM) && (dividend != '1);
          valid        <= 1'b1;
          clr_meas     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DIST_AVG_EN
  always_ff @(posedge CLKOUT) begin
    if (reset) begin
      hist[0] <= '0;
      hist[1] <= '0;
      hist[2] <= '0;
      hist[3] <= '0;
      filled  <= 1'b0;
      avg_q   <= '0;
    end else if (state == AVG) begin
      hist[0] <= quot;
      hist[1] <= filled ? hist[0] : quot;
      hist[2] <= filled ? hist[1] : quot;
      hist[3] <= filled ? hist[2] : quot;
      filled  <= 1'b1;
      avg_q   <= avg_sum[COUNT_W+1:2];
    end
  end
`endif

endmodule

// File: tb/tb_distancia_calc.sv
// Directed bench for distancia_calc (default build): latency, quotients, flags, reset abort,
// and the WAIT_CLR guard against a sticky calculate flag.
module tb_distancia_calc;

  logic       CLKOUT = 1'b0;
  logic       reset;
  logic [7:0] count;
  logic       calculate;
  logic [7:0] distance;
  logic       valid, busy, clr_meas, out_of_range, near_alarm;

  int errors = 0;
  int checks = 0;

  distancia_calc #(.COUNT_W(8), .TICKS_PER_CM(6), .NEAR_CM(20)) dut (
    .CLKOUT(CLKOUT), .reset(reset), .count(count), .calculate(calculate),
    .distance(distance), .valid(valid), .busy(busy), .clr_meas(clr_meas),
    .out_of_range(out_of_range), .near_alarm(near_alarm)
  );

  always #5 CLKOUT = ~CLKOUT;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKOUT);
    #1;
  endtask

  // Raise calculate with count c; the next edge is edge 1, valid expected after edge 10.
  task automatic run_meas(input string tag, input logic [7:0] c, input int d, input int n,
                          input int o, input bit drop);
    bit got;
    int lat;
    got = 0;
    lat = 0;
    count = c;
    calculate = 1'b1;
    for (int e = 1; e <= 20 && !got; e++) begin
      tick();
      if (valid) begin
        got = 1;
        lat = e;
      end else if (e <= 9) begin
        check({tag, "_busy"}, int'(busy), 1);
      end
    end
    check({tag, "_valid_seen"}, int'(got), 1);
    check({tag, "_latency"}, lat, 10);
    check({tag, "_distance"}, int'(distance), d);
    check({tag, "_near"}, int'(near_alarm), n);
    check({tag, "_oor"}, int'(out_of_range), o);
    check({tag, "_clr"}, int'(clr_meas), 1);
    check({tag, "_busy_wait"}, int'(busy), 1);
    if (drop) begin
      calculate = 1'b0;
      count = 8'hA5;
      tick();
      check({tag, "_valid_drop"}, int'(valid), 0);
      check({tag, "_clr_drop"}, int'(clr_meas), 0);
      check({tag, "_idle"}, int'(busy), 0);
      check({tag, "_hold"}, int'(distance), d);
    end
  endtask

  initial begin
    int nvalid;
    reset = 1'b1;
    count = 8'd0;
    calculate = 1'b0;
    tick();
    tick();
    check("rst_distance", int'(distance), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_clr", int'(clr_meas), 0);
    check("rst_oor", int'(out_of_range), 0);
    check("rst_near", int'(near_alarm), 0);
    reset = 1'b0;
    tick();

    run_meas("c120", 8'd120, 20, 0, 0, 1);
    run_meas("c60",  8'd60,  10, 1, 0, 1);
    run_meas("c0",   8'd0,   0,  1, 0, 1);
    run_meas("c5",   8'd5,   0,  1, 0, 1);
    run_meas("c6",   8'd6,   1,  1, 0, 1);
    run_meas("c119", 8'd119, 19, 1, 0, 1);
    run_meas("c126", 8'd126, 21, 0, 0, 1);
    run_meas("c254", 8'd254, 42, 0, 0, 1);
    run_meas("c255", 8'd255, 42, 0, 1, 1);

    // Reset during the 4th DIV cycle aborts the sample.
    count = 8'd100;
    calculate = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("abort_busy_pre", int'(busy), 1);
    reset = 1'b1;
    calculate = 1'b0;
    tick();
    check("abort_distance", int'(distance), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_clr", int'(clr_meas), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_oor", int'(out_of_range), 0);
    check("abort_near", int'(near_alarm), 0);
    reset = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid || clr_meas) nvalid++;
    end
    check("abort_no_valid", nvalid, 0);

    // Sticky calculate must not retrigger until it drops.
    run_meas("sticky", 8'd90, 15, 1, 0, 0);
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      count = 8'd12;
      tick();
      if (valid) nvalid++;
    end
    check("sticky_extra_valid", nvalid, 0);
    check("sticky_busy", int'(busy), 1);
    check("sticky_hold", int'(distance), 15);
    calculate = 1'b0;
    tick();
    check("sticky_idle", int'(busy), 0);
    run_meas("c30", 8'd30, 5, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
